// File: rtl/booth_simd_pkg.sv
// Shared definitions for the SIMD Booth multiplier: mode codes, FSM states,
// per-mode iteration counts and the nibble carry-cut pattern.
package booth_simd_pkg;

    localparam logic [1:0] MODE_16  = 2'b00;
    localparam logic [1:0] MODE_8   = 2'b01;
    localparam logic [1:0] MODE_4   = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Initial iteration counter: lane width minus one.
    function automatic logic [3:0] iter_count(input logic [1:0] mode);
        case (mode)
            MODE_16: iter_count = 4'd15;
            MODE_8:  iter_count = 4'd7;
            MODE_4:  iter_count = 4'd3;
            default: iter_count = 4'd0;
        endcase
    endfunction

    // Bit n set: nibble n starts a lane, so its carry-in comes from the flag.
    function automatic logic [3:0] carry_cut_mask(input logic [1:0] mode);
        case (mode)
            MODE_8:  carry_cut_mask = 4'b0101;
            MODE_4:  carry_cut_mask = 4'b1111;
            default: carry_cut_mask = 4'b0001;
        endcase
    endfunction

    // Index of the lowest nibble of the lane that contains nibble nib.
    function automatic logic [1:0] lane_base(input logic [1:0] mode, input logic [1:0] nib);
        case (mode)
            MODE_8:  lane_base = {nib[1], 1'b0};
            MODE_4:  lane_base = nib;
            default: lane_base = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_addsub.sv
// Combinational 16-bit add/subtract split into 16/8/4-bit lanes, reporting the
// overflow-corrected sign at the top bit of every nibble.
module simd_lane_addsub
    import booth_simd_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] m,
    input  logic [3:0]  sub,
    input  logic [1:0]  mode,
    output logic [15:0] sum,
    output logic [3:0]  nib_sign
);

    logic [3:0] cut;
    assign cut = carry_cut_mask(mode);

    always_comb begin
        logic       carry;
        logic       c_in;
        logic [3:0] m_x;
        logic [3:0] lo;
        logic [1:0] hi;
        carry    = 1'b0;
        c_in     = 1'b0;
        m_x      = '0;
        lo       = '0;
        hi       = '0;
        sum      = '0;
        nib_sign = '0;
        for (int n = 0; n < 4; n++) begin
            m_x  = m[4*n +: 4] ^ {4{sub[n]}};
            c_in = cut[n] ? sub[n] : carry;
            // Split at bit 3 so both the carry into and out of the msb are visible.
            lo   = {1'b0, a[4*n +: 3]} + {1'b0, m_x[2:0]} + {3'b000, c_in};
            hi   = {1'b0, a[4*n+3]} + {1'b0, m_x[3]} + {1'b0, lo[3]};
            sum[4*n +: 4] = {hi[0], lo[2:0]};
            nib_sign[n]   = hi[0] ^ lo[3] ^ hi[1];
            carry         = hi[1];
        end
    end

endmodule

// File: rtl/booth_simd_seq.sv
// Sequential radix-2 Booth multiplier: one 16x16, two 8x8 or four 4x4 signed
// products per request, one iteration per clock with lane-local shifting.
module booth_simd_seq
    import booth_simd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] product,
    output logic        err,
    output logic        out_valid,
    input  logic        out_ready
);

    state_e      state_reg, state_next;
    logic [1:0]  mode_reg;
    logic [15:0] acc_reg, q_reg, m_reg;
    logic [3:0]  qm1_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] product_reg;
    logic        err_reg, out_valid_reg;

    logic        accept;
    logic [3:0]  sub_flag;
    logic [15:0] m_eff, sum;
    logic [3:0]  lane_sign;
    logic [15:0] acc_sh, q_sh;
    logic [3:0]  qm1_sh;
    logic [31:0] prod_sh;

    assign accept = in_valid & in_ready;

    // Booth recoding: each nibble follows the {Q[0], q_m1} pair of its lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_recode
            logic [1:0] lo_nib;
            logic [1:0] pair;
            assign lo_nib = lane_base(mode_reg, 2'(gi));
            assign pair   = {q_reg[{lo_nib, 2'b00}], qm1_reg[lo_nib]};
            assign sub_flag[gi]     = (pair == 2'b10);
            assign m_eff[4*gi +: 4] = (pair[1] ^ pair[0]) ? m_reg[4*gi +: 4] : 4'b0000;
        end
    endgenerate

    simd_lane_addsub u_addsub (
        .a        (acc_reg),
        .m        (m_eff),
        .sub      (sub_flag),
        .mode     (mode_reg),
        .sum      (sum),
        .nib_sign (lane_sign)
    );

    // Lane-local arithmetic shift of {A, Q, q_m1}; the true sign refills A's msb.
    always_comb begin
        acc_sh  = '0;
        q_sh    = '0;
        qm1_sh  = '0;
        prod_sh = '0;
        case (mode_reg)
            MODE_8: begin
                for (int l = 0; l < 2; l++) begin
                    acc_sh[8*l +: 8]   = {lane_sign[2*l+1], sum[8*l+1 +: 7]};
                    q_sh[8*l +: 8]     = {sum[8*l], q_reg[8*l+1 +: 7]};
                    qm1_sh[2*l]        = q_reg[8*l];
                    prod_sh[16*l +: 16] = {acc_sh[8*l +: 8], q_sh[8*l +: 8]};
                end
            end
            MODE_4: begin
                for (int l = 0; l < 4; l++) begin
                    acc_sh[4*l +: 4]  = {lane_sign[l], sum[4*l+1 +: 3]};
                    q_sh[4*l +: 4]    = {sum[4*l], q_reg[4*l+1 +: 3]};
                    qm1_sh[l]         = q_reg[4*l];
                    prod_sh[8*l +: 8] = {acc_sh[4*l +: 4], q_sh[4*l +: 4]};
                end
            end
            default: begin
                acc_sh    = {lane_sign[3], sum[15:1]};
                q_sh      = {sum[0], q_reg[15:1]};
                qm1_sh[0] = q_reg[0];
                prod_sh   = {acc_sh, q_sh};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = (mode == MODE_RSV) ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt_reg == 4'd0) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_reg == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= MODE_16;
            acc_reg       <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            qm1_reg       <= '0;
            cnt_reg       <= '0;
            product_reg   <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= (state_next == ST_DONE);
            if (accept) begin
                mode_reg    <= mode;
                m_reg       <= a;
                q_reg       <= b;
                acc_reg     <= '0;
                qm1_reg     <= '0;
                cnt_reg     <= iter_count(mode);
                product_reg <= '0;
                err_reg     <= (mode == MODE_RSV);
            end else if (state_reg == ST_RUN) begin
                acc_reg <= acc_sh;
                q_reg   <= q_sh;
                qm1_reg <= qm1_sh;
                cnt_reg <= cnt_reg - 4'd1;
                if (cnt_reg == 4'd0) product_reg <= prod_sh;
            end
        end
    end

    assign product   = product_reg;
    assign err       = err_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_booth_simd_seq.sv
// Scoreboard bench for booth_simd_seq: the driver queues hand-computed results,
// a negedge monitor checks latency, product and err whenever out_valid is up.
module tb_booth_simd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] product;
    logic        err;
    logic        out_valid;
    logic        out_ready = 1'b1;

    typedef struct {
        logic [31:0] prod;
        logic        err;
        int          lat;
        int          acc_cyc;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_miss = 0;
    logic prev_valid = 1'b0;

    booth_simd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_miss++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Monitor: latency on the rising edge of out_valid, payload on every valid cycle.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                timeout("unexpected_out_valid");
            end else begin
                check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            end
        end
        if (out_valid && sb.size() != 0) begin
            check("product", product, sb[0].prod);
            check("err", {31'b0, err}, {31'b0, sb[0].err});
            if (out_ready) begin
                $display("txn mode=%0d product=%h err=%b", sb[0].mode, product, err);
                void'(sb.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    // Drive one request; the expected entry is queued on the accepting edge.
    task automatic issue(input logic [1:0] m, input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp_prod, input logic exp_err, input int lat,
                         input bit push);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            timeout("in_ready");
            return;
        end
        mode = m;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.prod = exp_prod;
            e.err = exp_err;
            e.lat = lat;
            e.acc_cyc = cyc;
            e.mode = m;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || !in_ready) && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (sb.size() != 0 || !in_ready) timeout("drain");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'b00, 16'h0003, 16'hFFFB, 32'hFFFFFFF1, 1'b0, 16, 1'b1);
        wait_drain();
        issue(2'b00, 16'h8000, 16'h8000, 32'h40000000, 1'b0, 16, 1'b1);
        wait_drain();
        issue(2'b00, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b0, 16, 1'b1);
        wait_drain();
        issue(2'b00, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 16, 1'b1);
        wait_drain();
        issue(2'b01, 16'h7F80, 16'h0280, 32'h00FE4000, 1'b0, 8, 1'b1);
        wait_drain();
        issue(2'b01, 16'h0505, 16'h0303, 32'h000F000F, 1'b0, 8, 1'b1);
        wait_drain();
        issue(2'b10, 16'h87F2, 16'h873D, 32'h4031FDFA, 1'b0, 4, 1'b1);
        wait_drain();
        issue(2'b10, 16'h8888, 16'h8888, 32'h40404040, 1'b0, 4, 1'b1);
        wait_drain();

        // Backpressure: hold DONE for five cycles while poking in_valid.
        out_ready = 1'b0;
        issue(2'b01, 16'h0A03, 16'h07FE, 32'h0046FFFA, 1'b0, 8, 1'b1);
        begin
            int waited;
            waited = 0;
            while (!out_valid && waited < 50) begin
                @(posedge clk);
                #1;
                waited++;
            end
            if (!out_valid) timeout("bp_out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            mode = 2'b00;
            a = 16'h1111;
            b = 16'h2222;
            in_valid = ~in_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("bp_idle_ready", {31'b0, in_ready}, 32'd1);
        check("bp_idle_valid", {31'b0, out_valid}, 32'd0);

        // Reserved mode goes straight to DONE, so out_valid shows in the following cycle.
        issue(2'b11, 16'h1234, 16'h5678, 32'h00000000, 1'b1, 0, 1'b1);
        wait_drain();
        issue(2'b00, 16'h0002, 16'h0003, 32'h00000006, 1'b0, 16, 1'b1);
        wait_drain();

        // Reset after three RUN iterations: result discarded, IDLE at once.
        issue(2'b00, 16'h1234, 16'h4321, 32'h0, 1'b0, 16, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_product", product, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b01, 16'h7F80, 16'h0280, 32'h00FE4000, 1'b0, 8, 1'b1);
        wait_drain();

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
        $finish;
    end

endmodule
